// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : Iterative 32x32 multiply (shift-add) and divide (restoring),
//               one bit per cycle, with signed/unsigned operand handling.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        op_mul_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic        r_op_mul;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_opnd;
    logic [64:0] r_work;

    logic [31:0] w_op1_mag;
    logic [31:0] w_op2_mag;
    logic [33:0] w_div_trial;
    logic [64:0] w_div_next;
    logic [32:0] w_mul_sum;
    logic [64:0] w_mul_next;
    logic [64:0] w_next;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_prod;
    logic [63:0] w_final;

    assign w_op1_mag = (signed_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    assign w_op2_mag = (signed_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

    // r_work holds {partial remainder, dividend/quotient} for divide and
    // {carry, product_hi, multiplier/product_lo} for multiply; r_opnd is the
    // divisor or multiplicand magnitude.
    always_comb begin
        w_div_trial = r_work[64:31] - {2'b00, r_opnd};
        if (!w_div_trial[33])
            w_div_next = {w_div_trial[32:0], r_work[30:0], 1'b1};
        else
            w_div_next = {r_work[63:0], 1'b0};

        w_mul_sum  = {1'b0, r_work[63:32]} + (r_work[0] ? {1'b0, r_opnd} : 33'd0);
        w_mul_next = {1'b0, w_mul_sum, r_work[31:1]};

        w_next  = r_op_mul ? w_mul_next : w_div_next;
        w_prod  = r_neg_q ? -w_next[63:0]  : w_next[63:0];
        w_quot  = r_neg_q ? -w_next[31:0]  : w_next[31:0];
        w_rem   = r_neg_r ? -w_next[63:32] : w_next[63:32];
        w_final = r_op_mul ? w_prod : {w_rem, w_quot};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= 5'd0;
            r_op_mul <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_opnd   <= 32'd0;
            r_work   <= 65'd0;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                    if (start_i && !annul_i) begin
                        r_op_mul <= op_mul_i;
                        r_neg_q  <= signed_i & (opdata1_i[31] ^ opdata2_i[31]);
                        r_neg_r  <= signed_i & opdata1_i[31];
                        r_cnt    <= 5'd0;
                        if (!op_mul_i && (opdata2_i == 32'd0)) begin
                            r_state <= c_DONE;
                            ready_o <= 1'b1;
                        end else begin
                            r_state <= c_BUSY;
                            r_opnd  <= op_mul_i ? w_op1_mag : w_op2_mag;
                            r_work  <= {33'd0, op_mul_i ? w_op2_mag : w_op1_mag};
                        end
                    end
                end
                c_BUSY: begin
                    if (annul_i || !start_i) begin
                        r_state <= c_IDLE;
                        r_cnt   <= 5'd0;
                    end else begin
                        r_work <= w_next;
                        r_cnt  <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state  <= c_DONE;
                            ready_o  <= 1'b1;
                            result_o <= w_final;
                        end
                    end
                end
                c_DONE: begin
                    if (!start_i || annul_i) begin
                        r_state  <= c_IDLE;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end
                end
                default: begin
                    r_state  <= c_IDLE;
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_iter
// Description : Self-checking bench for muldiv_iter (vector table, scoreboard,
//               directed abort/reset/hold sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        op_mul_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;

    muldiv_iter dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .op_mul_i  (op_mul_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .result_o  (result_o),
        .ready_o   (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mul;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs [12];
    logic [63:0] sb_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference built on native signed/unsigned arithmetic (truncating divide).
    function automatic logic [63:0] model(input logic mul, input logic sgn,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (mul) begin
            if (sgn) return 64'(longint'($signed(a)) * longint'($signed(b)));
            return {32'd0, a} * {32'd0, b};
        end
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic run_op(input logic mul, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int hold);
        int          lat;
        int          exp_lat;
        logic        got;
        logic        busy_nz;
        logic [63:0] exp_pop;
        logic [63:0] held;
        exp_lat   = (!mul && b == 32'd0) ? 1 : 33;
        op_mul_i  = mul;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        annul_i   = 1'b0;
        start_i   = 1'b1;
        sb_q.push_back(exp);
        lat = 0; got = 1'b0; busy_nz = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            op_mul_i  = 1'($urandom_range(1));
            signed_i  = 1'($urandom_range(1));
            got = ready_o;
            if (!got && result_o !== 64'd0) busy_nz = 1'b1;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("busy_result_zero", 64'(busy_nz), 64'd0);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 64'(sb_q.size()), 64'd1);
        end else begin
            exp_pop = sb_q.pop_front();
            check("result", result_o, exp_pop);
        end
        held = result_o;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_ready", 64'(ready_o), 64'd1);
            check("hold_result", result_o, held);
        end
        start_i = 1'b0;
        @(posedge clk); #1;
        check("drop_ready", 64'(ready_o), 64'd0);
        check("drop_result", result_o, 64'd0);
    endtask

    initial begin
        logic seen;
        logic nz;
        vecs[0]  = '{1'b0, 1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
        vecs[1]  = '{1'b0, 1'b1, 32'hFFFFFFF9,   32'h2,          64'hFFFFFFFF_FFFFFFFD};
        vecs[2]  = '{1'b1, 1'b1, 32'hFFFFFFFD,   32'd5,          64'hFFFFFFFF_FFFFFFF1};
        vecs[3]  = '{1'b1, 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE_00000001};
        vecs[4]  = '{1'b0, 1'b0, 32'd5,          32'd0,          64'h0};
        vecs[5]  = '{1'b0, 1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000};
        vecs[6]  = '{1'b0, 1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD};
        vecs[7]  = '{1'b0, 1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF};
        vecs[8]  = '{1'b1, 1'b1, 32'h80000000,   32'h80000000,   64'h40000000_00000000};
        vecs[9]  = '{1'b1, 1'b0, 32'd0,          32'h12345678,   64'h0};
        vecs[10] = '{1'b0, 1'b0, 32'd3,          32'd10,         64'h00000003_00000000};
        vecs[11] = '{1'b0, 1'b1, 32'hFFFFFFFB,   32'd0,          64'h0};

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_mul_i = 1'b0;
        signed_i = 1'b0; opdata1_i = 32'd0; opdata2_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;

        // annul held in IDLE must block acceptance
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd0;
        seen = 1'b0;
        repeat (5) begin @(posedge clk); #1; seen |= ready_o; end
        check("idle_annul_no_ready", 64'(seen), 64'd0);
        start_i = 1'b0; annul_i = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].mul, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, (i == 0) ? 3 : 0);

        for (int k = 0; k < 6; k++) begin
            logic        m;
            logic        s;
            logic [31:0] a;
            logic [31:0] b;
            m = 1'(k % 2);
            s = 1'((k / 2) % 2);
            a = $urandom;
            b = (k >= 4) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_op(m, s, a, b, model(m, s, a, b), 1);
        end

        // annul at BUSY iteration 10
        op_mul_i = 1'b0; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        start_i = 1'b1; seen = 1'b0; nz = 1'b0;
        for (int i = 1; i <= 11; i++) begin @(posedge clk); #1; seen |= ready_o; end
        annul_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; annul_i = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= ready_o;
            nz |= (result_o !== 64'd0);
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        check("annul_result_zero", 64'(nz), 64'd0);

        // reset at BUSY iteration 20 of a second operation
        op_mul_i = 1'b1; signed_i = 1'b1; opdata1_i = 32'hFFFFFFFD; opdata2_i = 32'd5;
        start_i = 1'b1; seen = 1'b0; nz = 1'b0;
        for (int i = 1; i <= 21; i++) begin @(posedge clk); #1; seen |= ready_o; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start_i = 1'b0;
        check("rst_mid_busy_ready", 64'(ready_o), 64'd0);
        repeat (40) begin
            @(posedge clk); #1;
            seen |= ready_o;
            nz |= (result_o !== 64'd0);
        end
        check("rst_no_ready", 64'(seen), 64'd0);
        check("rst_result_zero", 64'(nz), 64'd0);

        run_op(1'b0, 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_iter.md
MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, named clk and rst as elsewhere in the codebase.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start_i  input  1  request; held high by the EX stage until ready_o is seen.
REQ-005 annul_i  input  1  cancel the in-flight operation.
REQ-006 op_mul_i  input  1  1 = multiply, 0 = divide; sampled at accept.
REQ-007 signed_i  input  1  1 = signed (mult/div), 0 = unsigned (multu/divu); sampled at accept.
REQ-008 opdata1_i  input  32  multiplicand or dividend; sampled at accept.
REQ-009 opdata2_i  input  32  multiplier or divisor; sampled at accept.
REQ-010 result_o  output  64  divide: {remainder[63:32], quotient[31:0]}; multiply: {product_hi, product_lo}.
REQ-011 ready_o  output  1  result_o valid.

Function
REQ-012 The block SHALL implement the states IDLE, BUSY and DONE.
REQ-013 In IDLE with start_i=1 and annul_i=0, the block SHALL latch the operands, op_mul_i and signed_i.
- Divide with opdata2_i=0: next state DONE, result 64'h0.
- Otherwise: next state BUSY, iteration counter cleared to 0.
REQ-014 Before iterating, the block SHALL convert signed operands to magnitudes. Operand sign bits SHALL be kept for the final correction.
REQ-015 Divide SHALL be radix-2 restoring, one quotient bit per BUSY cycle, using a 65-bit partial-remainder/quotient shift register.
REQ-016 Multiply SHALL be shift-add, one multiplier bit per BUSY cycle, into a 64-bit accumulator.
REQ-017 BUSY SHALL last exactly 32 cycles. On the edge ending the 32nd iteration, the block SHALL apply sign correction, load result_o and enter DONE.
REQ-018 Latency: start_i first high in cycle T (state IDLE) SHALL give ready_o=1 in cycle T+33. For divide-by-zero, ready_o=1 in cycle T+1.
REQ-019 Signed divide correction:
- quotient negated iff sign1 XOR sign2;
- remainder takes the sign of the dividend.
REQ-020 Signed multiply correction: the 64-bit product SHALL be negated iff sign1 XOR sign2.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0 (wrap, no trap).
REQ-022 In DONE, ready_o SHALL be 1 and result_o SHALL be held stable while start_i=1.
REQ-023 In DONE with start_i=0, the next state SHALL be IDLE, with ready_o=0 and result_o=0 in the following cycle.
REQ-024 In BUSY, annul_i=1 or start_i=0 SHALL abort: next state IDLE, no ready_o pulse, result_o stays 0.
REQ-025 annul_i=1 in IDLE SHALL suppress acceptance. annul_i=1 in DONE SHALL behave as start_i=0.
REQ-026 Operand input changes after acceptance SHALL NOT affect the result.
REQ-027 ready_o SHALL be 0 in IDLE and BUSY. result_o SHALL be 0 in IDLE and BUSY.
REQ-028 A new start_i in the cycle after DONE→IDLE SHALL be accepted normally (back-to-back operations).

Reset
REQ-029 rst=1 SHALL force state IDLE, counter 0, ready_o=0 and result_o=64'h0 on the next edge, in any state including mid-BUSY.
REQ-030 After rst deasserts, the block SHALL accept only a fresh start_i sampled in IDLE; no partial result SHALL ever appear.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Unsigned divide 100/7 → ready_o in cycle T+33, result_o=64'h00000002_0000000E.
- Signed divide -7/2 (0xFFFFFFF9/0x2) → result_o=64'hFFFFFFFF_FFFFFFFD.
- Signed multiply -3*5 → result_o=64'hFFFFFFFF_FFFFFFF1. Unsigned multiply 0xFFFFFFFF*0xFFFFFFFF → 64'hFFFFFFFE_00000001.
- Divide 5/0 → ready_o in cycle T+1, result_o=0. Signed 0x80000000/0xFFFFFFFF → 64'h00000000_80000000.
- annul_i=1 at BUSY iteration 10, then rst=1 at iteration 20 of a second operation → state IDLE, ready_o never asserted for either.
- ready_o held while start_i stays high for 3 extra cycles → result_o stable. start_i drop → ready_o=0 next cycle. Immediate new start → correct second result.
